// File: rtl/logic_gates.sv
// Registered bitwise logic unit: all seven two-input/one-input gate results of
// in1/in2 are captured together on an accepted pair, one cycle after the sample.
module logic_gates #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_not,
   output logic [WIDTH-1:0] out_and,
   output logic [WIDTH-1:0] out_or,
   output logic [WIDTH-1:0] out_nand,
   output logic [WIDTH-1:0] out_nor,
   output logic [WIDTH-1:0] out_xor,
   output logic [WIDTH-1:0] out_xnor
);

   // Results load only on accept, so operands are never observed while
   // in_valid is low; an idle cycle drops out_valid but keeps the last results.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_not   <= '0;
         out_and   <= '0;
         out_or    <= '0;
         out_nand  <= '0;
         out_nor   <= '0;
         out_xor   <= '0;
         out_xnor  <= '0;
      end else if (in_valid) begin
         out_valid <= 1'b1;
         out_not   <= ~in1;
         out_and   <= in1 & in2;
         out_or    <= in1 | in2;
         out_nand  <= ~(in1 & in2);
         out_nor   <= ~(in1 | in2);
         out_xor   <= in1 ^ in2;
         out_xnor  <= ~(in1 ^ in2);
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_logic_gates.sv
// Directed bench for logic_gates: a 1-bit and an 8-bit instance driven in
// lockstep, outputs checked #1 after each rising edge against hand-computed values.
module tb_logic_gates;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in1_w1, in2_w1;
   logic [7:0] in1_w8, in2_w8;

   logic       valid_w1, valid_w8;
   logic       not_w1, and_w1, or_w1, nand_w1, nor_w1, xor_w1, xnor_w1;
   logic [7:0] not_w8, and_w8, or_w8, nand_w8, nor_w8, xor_w8, xnor_w8;

   logic [6:0]  res_w1;
   logic [55:0] res_w8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Results packed as {NOT, AND, OR, NAND, NOR, XOR, XNOR}
   assign res_w1 = {not_w1, and_w1, or_w1, nand_w1, nor_w1, xor_w1, xnor_w1};
   assign res_w8 = {not_w8, and_w8, or_w8, nand_w8, nor_w8, xor_w8, xnor_w8};

   logic_gates #(.WIDTH(1)) dut_w1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in1(in1_w1), .in2(in2_w1),
      .out_valid(valid_w1), .out_not(not_w1), .out_and(and_w1), .out_or(or_w1),
      .out_nand(nand_w1), .out_nor(nor_w1), .out_xor(xor_w1), .out_xnor(xnor_w1)
   );

   logic_gates #(.WIDTH(8)) dut_w8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in1(in1_w8), .in2(in2_w8),
      .out_valid(valid_w8), .out_not(not_w8), .out_and(and_w8), .out_or(or_w8),
      .out_nand(nand_w8), .out_nor(nor_w8), .out_xor(xor_w8), .out_xnor(xnor_w8)
   );

   task automatic applyStimulus(input logic r, input logic v,
                                input logic a1, input logic b1,
                                input logic [7:0] a8, input logic [7:0] b8);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      in1_w1   = a1;
      in2_w1   = b1;
      in1_w8   = a8;
      in2_w8   = b8;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic exp_valid,
                              input logic [6:0] exp_w1, input logic [55:0] exp_w8);
      checks++;
      assert (valid_w1 === exp_valid) else begin
         errors++;
         $error("[TB] FAIL %s valid_w1: observed %b expected %b", tag, valid_w1, exp_valid);
      end
      checks++;
      assert (res_w1 === exp_w1) else begin
         errors++;
         $error("[TB] FAIL %s res_w1: observed %b expected %b", tag, res_w1, exp_w1);
      end
      checks++;
      assert (valid_w8 === exp_valid) else begin
         errors++;
         $error("[TB] FAIL %s valid_w8: observed %b expected %b", tag, valid_w8, exp_valid);
      end
      checks++;
      assert (res_w8 === exp_w8) else begin
         errors++;
         $error("[TB] FAIL %s res_w8: observed %h expected %h", tag, res_w8, exp_w8);
      end
   endtask

   localparam logic [6:0]  W1_00 = 7'b1001101;
   localparam logic [6:0]  W1_01 = 7'b1011010;
   localparam logic [6:0]  W1_10 = 7'b0011010;
   localparam logic [6:0]  W1_11 = 7'b0110001;
   localparam logic [55:0] W8_F0_AA = 56'h0F_A0_FA_5F_05_5A_A5;
   localparam logic [55:0] W8_3C_0F = 56'hC3_0C_3F_F3_C0_33_CC;
   localparam logic [55:0] W8_00_FF = 56'hFF_00_FF_FF_00_FF_00;

   initial begin
      rst = 1'b1; in_valid = 1'b0;
      in1_w1 = 1'b0; in2_w1 = 1'b0; in1_w8 = '0; in2_w8 = '0;

      // Reset beats in_valid with all-ones operands
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
      checkOutput("reset_0", 1'b0, 7'b0, 56'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
      checkOutput("reset_1", 1'b0, 7'b0, 56'h0);

      // Four back-to-back pairs, one result per cycle
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 8'hAA);
      checkOutput("stream_00", 1'b1, W1_00, W8_F0_AA);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h0F);
      checkOutput("stream_01", 1'b1, W1_01, W8_3C_0F);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF);
      checkOutput("stream_10", 1'b1, W1_10, W8_00_FF);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hF0, 8'hAA);
      checkOutput("stream_11", 1'b1, W1_11, W8_F0_AA);

      // Idle with toggling and unknown operands: results hold, valid drops
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 8'h33);
      checkOutput("hold_0", 1'b0, W1_11, W8_F0_AA);
      applyStimulus(1'b0, 1'b0, 1'bx, 1'bx, 8'hxx, 8'hxx);
      checkOutput("hold_x", 1'b0, W1_11, W8_F0_AA);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hAA, 8'hCC);
      checkOutput("hold_2", 1'b0, W1_11, W8_F0_AA);

      // Mid-stream reset discards the in-flight pair, stream then resumes
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h0F);
      checkOutput("pre_rst", 1'b1, W1_01, W8_3C_0F);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hF0, 8'hAA);
      checkOutput("mid_rst", 1'b0, 7'b0, 56'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF);
      checkOutput("resume_0", 1'b1, W1_10, W8_00_FF);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 8'hAA);
      checkOutput("resume_1", 1'b1, W1_00, W8_F0_AA);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h34);
      checkOutput("final_idle", 1'b0, W1_00, W8_F0_AA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
